// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS sequencer: opcodes, ALU codes, states, strobe bit positions.
// Pure declarations; no logic, no latency, no backpressure.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    localparam logic [3:0] ALU_IDLE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;

    // muxctrl bit positions; alu_src_b occupies two bits starting at MX_SRCB
    localparam int MX_IORD      = 0;
    localparam int MX_REG_DST   = 1;
    localparam int MX_MEM_TO_REG = 2;
    localparam int MX_SRCA      = 3;
    localparam int MX_SRCB      = 4;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;

    localparam int MC_REG_WE  = 0;
    localparam int MC_MEM_WE  = 1;
    localparam int MC_MEM_REQ = 2;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ADD, CL_LW, CL_SW, CL_BEQ, CL_J, CL_ILL
    } iclass_t;

endpackage

// File: rtl/mips_seq_decode.sv
// Instruction classifier: op/func -> instruction class consumed by the sequencer FSM.
// Combinational, zero latency; no backpressure.
module mips_seq_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    iclass
);

    always_comb begin
        iclass = CL_ILL;
        case (op)
            OP_RTYPE: iclass = (func == FN_ADD) ? CL_ADD : CL_ILL;
            OP_LW:    iclass = CL_LW;
            OP_SW:    iclass = CL_SW;
            OP_BEQ:   iclass = CL_BEQ;
            OP_J:     iclass = CL_J;
            default:  iclass = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_seq.sv
// Multi-cycle MIPS sequencer (FETCH/DECODE/EXEC/MEM/WB) driving datapath controls and a retire counter.
// CPI add 4, lw 5, sw 4, beq 3, j 2; each mem_ready-low cycle in FETCH/MEM stalls one cycle.
// Optional MIPS_SEQ_ILLEGAL_TRAP_EN: illegal instructions park in TRAP instead of retiring as NOP.
module mips_multicycle_seq
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [6:0]       muxctrl,
    output logic [2:0]       memctrl,
    output logic [3:0]       aluctrl,
    output logic [1:0]       pc_src,
    output logic             pc_we,
    output logic             ir_we,
    output logic             tgt_we,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired,
    output logic             trap
);

    state_t     state, state_nxt;
    iclass_t    iclass;
    logic [6:0] mux_c;
    logic [2:0] mem_c;
    logic [3:0] alu_c;
    logic [1:0] pcs_c;
    logic       pcw_c, irw_c, tgw_c, retire_c, trap_c;

    mips_seq_decode u_decode (
        .op     (op),
        .func   (func),
        .iclass (iclass)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (retire_c)
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_nxt = state;
        mux_c     = '0;
        mem_c     = '0;
        alu_c     = ALU_IDLE;
        pcs_c     = PC_ALU;
        pcw_c     = 1'b0;
        irw_c     = 1'b0;
        tgw_c     = 1'b0;
        retire_c  = 1'b0;
        trap_c    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_c[MC_MEM_REQ]      = 1'b1;
                mux_c[MX_SRCB +: 2]    = SRCB_FOUR;
                alu_c                  = ALU_ADD;
                if (mem_ready) begin
                    irw_c     = 1'b1;
                    pcw_c     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // speculatively compute the branch target while the class resolves
                mux_c[MX_SRCB +: 2] = SRCB_SHIFT;
                alu_c               = ALU_ADD;
                tgw_c               = 1'b1;
                case (iclass)
                    CL_ADD, CL_LW, CL_SW, CL_BEQ: state_nxt = S_EXEC;
                    CL_J: begin
                        pcs_c     = PC_JUMP;
                        pcw_c     = 1'b1;
                        retire_c  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: begin
`ifdef MIPS_SEQ_ILLEGAL_TRAP_EN
                        state_nxt = S_TRAP;
`else
                        retire_c  = 1'b1;
                        state_nxt = S_FETCH;
`endif
                    end
                endcase
            end
            S_EXEC: begin
                mux_c[MX_SRCA] = 1'b1;
                alu_c          = ALU_ADD;
                case (iclass)
                    CL_ADD: state_nxt = S_WB;
                    CL_LW, CL_SW: begin
                        mux_c[MX_SRCB +: 2] = SRCB_IMM;
                        state_nxt           = S_MEM;
                    end
                    CL_BEQ: begin
                        alu_c     = ALU_SUB;
                        pcs_c     = PC_BRANCH;
                        pcw_c     = zero;
                        retire_c  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_c[MC_MEM_REQ] = 1'b1;
                mem_c[MC_MEM_WE]  = (iclass == CL_SW);
                mux_c[MX_IORD]    = 1'b1;
                if (mem_ready) begin
                    if (iclass == CL_LW) begin
                        irw_c     = 1'b1;
                        state_nxt = S_WB;
                    end else begin
                        retire_c  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                mem_c[MC_REG_WE]     = 1'b1;
                mux_c[MX_REG_DST]    = (iclass == CL_ADD);
                mux_c[MX_MEM_TO_REG] = (iclass == CL_LW);
                retire_c             = 1'b1;
                state_nxt            = S_FETCH;
            end
            S_TRAP: begin
`ifdef MIPS_SEQ_ILLEGAL_TRAP_EN
                trap_c    = 1'b1;
                state_nxt = S_TRAP;
`else
                state_nxt = S_FETCH;
`endif
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // outputs are forced quiet while reset is held, including the FETCH request
    assign muxctrl = reset ? mux_c : '0;
    assign memctrl = reset ? mem_c : '0;
    assign aluctrl = reset ? alu_c : ALU_IDLE;
    assign pc_src  = reset ? pcs_c : PC_ALU;
    assign pc_we   = reset & pcw_c;
    assign ir_we   = reset & irw_c;
    assign tgt_we  = reset & tgw_c;
    assign trap    = reset & trap_c;
    assign state_o = state;

endmodule

// File: doc/mips_multicycle_seq.md
Name: mips_multicycle_seq

Overview:
- Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- It drives datapath mux selects, register/memory strobes and ALU control, and handshakes with a single shared instruction/data memory port.
- Supported instructions: R-type add, lw, sw, beq, j. Also counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- op  in  6  IR[31:26], valid from DECODE onward
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational from current ALU op
- mem_ready  in  1  memory completes the current request this cycle
- muxctrl  out  7  [0] iord (1=ALUOut addr), [1] reg_dst (1=rd), [2] mem_to_reg, [3] alu_src_a (1=A reg), [5:4] alu_src_b (00=B, 01=4, 10=sign-ext imm, 11=imm<<2), [6] reserved 0
- memctrl  out  3  [0] reg_we, [1] mem_we, [2] mem_req
- aluctrl  out  4  0010 add, 0110 sub, 0000 idle
- pc_src  out  2  00=ALU result (PC+4), 01=branch target reg, 10=jump {PC[31:28],IR[25:0],00}
- pc_we  out  1  PC write strobe
- ir_we  out  1  IR and MDR capture strobe (MDR in MEM state)
- tgt_we  out  1  branch-target register write
- state_o  out  3  current state, debug
- retired  out  CNT_W  retired instruction count
- trap  out  1  see Optional Feature

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Reset value: FETCH.
- All outputs are 0 whenever no state below drives them, including during reset. retired=0 under reset.
- Reset asserted in any state, including mid memory wait: immediate return to FETCH with mem_req dropped; no retire.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0 (PC), alu_src_b=01, aluctrl=add, pc_src=00.
  - Hold until mem_ready=1. In that cycle ir_we=1 and pc_we=1 (Mealy), then go to DECODE.
  - mem_req stays high through all wait cycles.
- DECODE:
  - alu_src_a=0, alu_src_b=11, aluctrl=add, tgt_we=1.
  - op=000000 with func=100000, op=100011 or op=101011 -> EXEC.
  - op=000100 (beq) -> EXEC.
  - op=000010 (j) -> pc_src=10, pc_we=1, retire, go to FETCH.
  - Any other op/func is illegal -> FETCH with retire (NOP behaviour).
- EXEC:
  - add: alu_src_a=1, alu_src_b=00, aluctrl=add -> WB.
  - lw/sw: alu_src_a=1, alu_src_b=10, aluctrl=add -> MEM.
  - beq: alu_src_a=1, alu_src_b=00, aluctrl=sub, pc_src=01, pc_we=zero, retire -> FETCH.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for sw only. Hold until mem_ready.
  - lw: ir_we=1 (MDR capture) on ready -> WB.
  - sw: retire on ready -> FETCH.
- WB:
  - reg_we=1; reg_dst=1 for add, 0 for lw; mem_to_reg=1 for lw. Retire -> FETCH.
- Retire: retired increments by 1 on the transition clock edge and wraps at 2^CNT_W-1 -> 0.
- CPI: add 4, lw 5, sw 4, beq 3, j 2 (with zero memory wait cycles). Each mem_ready-low cycle adds 1.
- op/func are sampled only in DECODE/EXEC/MEM/WB. Changes during FETCH are ignored.

Optional Feature:
- Macro MIPS_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction in DECODE -> TRAP, no retire. TRAP holds forever with trap=1 and all strobes 0; exit only by reset.
- Undefined: the trap output is tied 0, TRAP is unreachable, and illegal instructions retire as NOP.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/func constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, FN_ADD);
  - ALU codes (ALU_ADD, ALU_SUB);
  - the state enum;
  - muxctrl/memctrl bit-index constants.
- Sub-module mips_seq_decode: combinational op/func -> instruction class (ADD/LW/SW/BEQ/J/ILLEGAL). The FSM consumes the class.

Test Plan:
- Reset low mid-FETCH with mem_ready=0 -> state_o=0, memctrl=000, retired=0 in the same cycle.
- add (op 000000, func 100000), mem_ready always 1 -> 4 cycles; WB shows memctrl=001, muxctrl[1]=1, aluctrl=0010 in EXEC; retired +1.
- lw (op 100011), mem_ready low 3 cycles in MEM -> mem_req held, iord=1 for 4 cycles; WB mem_to_reg=1, reg_dst=0; total 8 cycles.
- beq with zero=1, then zero=0 -> first: pc_we=1, pc_src=01 in EXEC; second: pc_we=0; both retire after 3 cycles.
- sw then j -> sw MEM: memctrl=110; j retires after 2 cycles with pc_src=10. Preload retired to all-ones and check wrap to 0.
- Illegal op 111111 -> without the macro: FETCH after DECODE, retired +1. With MIPS_SEQ_ILLEGAL_TRAP_EN: state_o=5, trap=1, held 20 cycles until reset.
